fpu_issue_ctrl: RTL

Hardware requester for the pfpu32_top FPU. It drives the FPU's decode/execute/flush pipeline controls and accepts one operation at a time over a valid/ready request channel. It waits for the class-appropriate FPU valid (arith or compare), captures result, flag and fpcsr, and returns them over a valid/ready response channel. A timeout and an abort path recover a hung or cancelled operation by flushing the FPU.

---
 rtl/fpu_issue_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_ctrl
//  Description : Single-outstanding requester for the pfpu32_top FPU. Takes
//                one operation over a valid/ready request channel. It drives
//                the FPU decode/execute strobes, then waits for the valid that
//                matches the op class (arith or compare). The captured result,
//                flag and fpcsr go back over a valid/ready response channel.
//                A wait timeout or an abort flushes the FPU to recover.
//  Ports       : clk, rst                     clock, sync active-high reset
//                req_* / req_ready_o          request channel
//                abort_i                      cancel in-flight op
//                rsp_*                        response channel
//                fpu_* (outputs)              FPU pipeline controls/operands
//                fpu_* (inputs)               FPU results and valids
//                stat_issued_o/stat_timeout_o wrapping statistics
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_issue_ctrl #(
  parameter int OPW     = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [OPW-1:0] req_op_i,
  input  logic [DW-1:0]  req_a_i,
  input  logic [DW-1:0]  req_b_i,
  input  logic [1:0]     req_rmode_i,
  input  logic           abort_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [DW-1:0]  rsp_result_o,
  output logic           rsp_cmp_o,
  output logic [10:0]    rsp_fpcsr_o,
  output logic           rsp_err_o,
  output logic           fpu_flush_o,
  output logic           fpu_decode_o,
  output logic           fpu_execute_o,
  output logic [OPW-1:0] fpu_op_o,
  output logic [DW-1:0]  fpu_a_o,
  output logic [DW-1:0]  fpu_b_o,
  output logic [1:0]     fpu_rmode_o,
  input  logic [DW-1:0]  fpu_result_i,
  input  logic           fpu_arith_valid_i,
  input  logic           fpu_cmp_flag_i,
  input  logic           fpu_cmp_valid_i,
  input  logic [10:0]    fpu_fpcsr_i,
  output logic [CW-1:0]  stat_issued_o,
  output logic [CW-1:0]  stat_timeout_o
);

  localparam int c_WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_cls_cmp;
  logic [c_WW-1:0] r_wait_cnt;
  logic            w_done;
  logic            w_unused;

  // The FPU-op marker bit is always forced, so the requester's copy is unused.
  assign w_unused    = req_op_i[OPW-1];
  assign req_ready_o = (r_state == ST_IDLE);

  // Only the valid of the latched class can complete the op.
  assign w_done = r_cls_cmp ? fpu_cmp_valid_i : fpu_arith_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cls_cmp      <= 1'b0;
      r_wait_cnt     <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_result_o   <= '0;
      rsp_cmp_o      <= 1'b0;
      rsp_fpcsr_o    <= '0;
      rsp_err_o      <= 1'b0;
      fpu_flush_o    <= 1'b0;
      fpu_decode_o   <= 1'b0;
      fpu_execute_o  <= 1'b0;
      fpu_op_o       <= '0;
      fpu_a_o        <= '0;
      fpu_b_o        <= '0;
      fpu_rmode_o    <= '0;
      stat_issued_o  <= '0;
      stat_timeout_o <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      fpu_flush_o   <= 1'b0;
      fpu_decode_o  <= 1'b0;
      fpu_execute_o <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_state       <= ST_ISSUE;
            r_cls_cmp     <= req_op_i[3];
            fpu_op_o      <= {1'b1, req_op_i[OPW-2:0]};
            fpu_a_o       <= req_a_i;
            fpu_b_o       <= req_b_i;
            fpu_rmode_o   <= req_rmode_i;
            fpu_decode_o  <= 1'b1;
            stat_issued_o <= stat_issued_o + 1'b1;
          end
        end

        ST_ISSUE: begin
          if (abort_i) begin
            fpu_flush_o <= 1'b1;
            fpu_op_o    <= '0;
            r_state     <= ST_IDLE;
          end else begin
            fpu_execute_o <= 1'b1;
            r_state       <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_wait_cnt <= '0;
          if (abort_i) begin
            fpu_flush_o <= 1'b1;
            fpu_op_o    <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Priority: abort, then a matching valid, then timeout.
          if (abort_i) begin
            fpu_flush_o <= 1'b1;
            fpu_op_o    <= '0;
            r_state     <= ST_IDLE;
          end else if (w_done) begin
            rsp_result_o <= r_cls_cmp ? '0 : fpu_result_i;
            rsp_cmp_o    <= r_cls_cmp ? fpu_cmp_flag_i : 1'b0;
            rsp_fpcsr_o  <= fpu_fpcsr_i;
            rsp_err_o    <= 1'b0;
            rsp_valid_o  <= 1'b1;
            fpu_op_o     <= '0;
            r_state      <= ST_RESP;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            fpu_flush_o    <= 1'b1;
            rsp_result_o   <= '0;
            rsp_cmp_o      <= 1'b0;
            rsp_fpcsr_o    <= '0;
            rsp_err_o      <= 1'b1;
            rsp_valid_o    <= 1'b1;
            fpu_op_o       <= '0;
            stat_timeout_o <= stat_timeout_o + 1'b1;
            r_state        <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
